logic_gates_checker: RTL and testbench

//   Synthesizable response checker for the logic_gates_2 AND/OR/NOT block.

---
 rtl/logic_gates_checker.sv | 86 ++++++++
 tb/tb_logic_gates_checker.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gates_checker.sv
// logic_gates_checker: settle-window response checker for an AND/OR/NOT gate block
module logic_gates_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             iClear,
  input  logic             iA,
  input  logic             iB,
  input  logic             iAnd,
  input  logic             iOr,
  input  logic             iNot,
  output logic             oBusy,
  output logic             oChkVld,
  output logic             oChkOk,
  output logic             oErr,
  output logic [CNT_W-1:0] oChkCnt,
  output logic [CNT_W-1:0] oErrCnt,
  output logic [4:0]       oFailVec
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK} stateT;
  stateT state, stateNxt;
  logic [CW-1:0] cnt, cntNxt;
  logic [1:0] prev;
  logic chg, chkNow, ok;
  assign chg = {iA, iB} != prev;
  assign ok = (iAnd == (iA & iB)) && (iOr == (iA | iB)) && (iNot == ~iA);
  assign oBusy = state != IDLE;
  always_comb begin
    stateNxt = state;
    cntNxt = cnt;
    chkNow = 1'b0;
    if (iEn) begin
      case (state)
        IDLE: begin
          stateNxt = chg ? SETTLE : IDLE;
          cntNxt = chg ? RELOAD : cnt;
        end
        SETTLE: begin
          stateNxt = (!chg && cnt == '0) ? CHECK : SETTLE;
          cntNxt = chg ? RELOAD : (cnt == '0 ? cnt : cnt - 1'b1);
        end
        CHECK: begin
          chkNow = 1'b1;
          stateNxt = chg ? SETTLE : IDLE;
          cntNxt = chg ? RELOAD : cnt;
        end
        default: stateNxt = IDLE;
      endcase
    end
  end
  // Counters saturate at all-ones; since errors only count on compares, oErrCnt never passes oChkCnt.
  always_ff @(posedge iClk) begin
    if (iRst || iClear) begin
      state <= IDLE;
      cnt <= '0;
      prev <= {iA, iB};
      oChkVld <= 1'b0;
      oChkOk <= 1'b0;
      oErr <= 1'b0;
      oChkCnt <= '0;
      oErrCnt <= '0;
      oFailVec <= '0;
    end else begin
      state <= stateNxt;
      cnt <= cntNxt;
      if (iEn) prev <= {iA, iB};
      oChkVld <= chkNow;
      oChkOk <= chkNow && ok;
      if (chkNow) begin
        oChkCnt <= oChkCnt + CNT_W'(~&oChkCnt);
        if (!ok) begin
          oErrCnt <= oErrCnt + CNT_W'(~&oErrCnt);
          if (!oErr) begin
            oErr <= 1'b1;
            oFailVec <= {iA, iB, iAnd, iOr, iNot};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_logic_gates_checker.sv
// tb_logic_gates_checker: scenario tasks plus random traffic against a deadline-based reference model
module tb_logic_gates_checker;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst, en, clr, a, b, gAnd, gOr, gNot;
  logic dBusy, dVld, dOk, dErr, sBusy, sVld, sOk, sErr;
  logic [15:0] dChk, dErrCnt;
  logic [1:0] sChk, sErrCnt;
  logic [4:0] dFail, sFail;
  int errors = 0, checks = 0;
  int cycle = 0, enc = 0, deadline = -1;
  int mChk = 0, mErr = 0, nVld = 0, nOk = 0, lastVld = -1, vldMis = 0, fault = 0;
  logic mErrFlag = 1'b0;
  logic [4:0] mFail = '0;
  logic [1:0] mPrev = '0;

  logic_gates_checker #(.SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .iClk(clk), .iRst(rst), .iEn(en), .iClear(clr), .iA(a), .iB(b),
    .iAnd(gAnd), .iOr(gOr), .iNot(gNot), .oBusy(dBusy), .oChkVld(dVld),
    .oChkOk(dOk), .oErr(dErr), .oChkCnt(dChk), .oErrCnt(dErrCnt), .oFailVec(dFail));
  logic_gates_checker #(.SETTLE_CYCLES(S), .CNT_W(2)) dutSmall (
    .iClk(clk), .iRst(rst), .iEn(en), .iClear(clr), .iA(a), .iB(b),
    .iAnd(gAnd), .iOr(gOr), .iNot(gNot), .oBusy(sBusy), .oChkVld(sVld),
    .oChkOk(sOk), .oErr(sErr), .oChkCnt(sChk), .oErrCnt(sErrCnt), .oFailVec(sFail));

  always #5 clk = ~clk;

  function automatic int sat3(input int x);
    return x > 3 ? 3 : x;
  endfunction

  // Gate block stand-in: fault 1 = AND stuck at 0, fault 2 = NOT output inverted.
  task automatic setIn(input logic na, input logic nb);
    a = na;
    b = nb;
    gAnd = (fault == 1) ? 1'b0 : (na & nb);
    gOr = na | nb;
    gNot = (fault == 2) ? na : ~na;
  endtask

  // One clock: the model schedules a compare S+1 enabled edges after the latest change.
  task automatic cyc();
    logic expVld, expOk, okNow;
    @(posedge clk);
    cycle++;
    expVld = 1'b0;
    expOk = 1'b0;
    if (rst || clr) begin
      deadline = -1;
      mPrev = {a, b};
      mChk = 0;
      mErr = 0;
      mErrFlag = 1'b0;
      mFail = '0;
    end else if (en) begin
      enc++;
      if (deadline == enc) begin
        okNow = (gAnd == (a & b)) && (gOr == (a | b)) && (gNot == !a);
        expVld = 1'b1;
        expOk = okNow;
        mChk++;
        if (!okNow) begin
          mErr++;
          if (!mErrFlag) begin
            mErrFlag = 1'b1;
            mFail = {a, b, gAnd, gOr, gNot};
          end
        end
        deadline = -1;
      end
      if ({a, b} != mPrev) deadline = enc + S + 1;
      mPrev = {a, b};
    end
    #1;
    if (dVld !== expVld || dOk !== expOk || dBusy !== (deadline != -1) ||
        sVld !== expVld || sOk !== expOk || sBusy !== (deadline != -1)) vldMis++;
    if (dVld === 1'b1) begin
      nVld++;
      lastVld = cycle;
    end
    if (dVld === 1'b1 && dOk === 1'b1) nOk++;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; fault = 0;
    setIn(1'b0, 1'b0);
    cyc();
    cyc();
    checks++;
    if ({dBusy, dVld, dOk, dErr, dChk, dErrCnt, dFail} !== '0) begin
      errors++; $display("FAIL reset_big: got busy=%b vld=%b err=%b chk=%0d errCnt=%0d fail=%b, want all 0", dBusy, dVld, dErr, dChk, dErrCnt, dFail);
    end
    checks++;
    if ({sBusy, sVld, sOk, sErr, sChk, sErrCnt, sFail} !== '0) begin
      errors++; $display("FAIL reset_small: got busy=%b vld=%b err=%b chk=%0d errCnt=%0d fail=%b, want all 0", sBusy, sVld, sErr, sChk, sErrCnt, sFail);
    end
    rst = 1'b0;
    vldMis = 0;
  endtask

  task automatic test_sequence();
    int base;
    logic [1:0] seq [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    en = 1'b1;
    base = nVld;
    nOk = 0;
    repeat (40) cyc();
    foreach (seq[i]) begin
      setIn(seq[i][1], seq[i][0]);
      repeat (40) cyc();
    end
    checks++;
    if (nVld - base != 4 || nOk != 4) begin
      errors++; $display("FAIL seq_pulses: got %0d pulses (%0d ok), want 4 (4 ok)", nVld - base, nOk);
    end
    checks++;
    if (dChk !== 16'd4 || dErrCnt !== 16'd0 || dErr !== 1'b0) begin
      errors++; $display("FAIL seq_counts: got chk=%0d errCnt=%0d err=%b, want 4 0 0", dChk, dErrCnt, dErr);
    end
    checks++;
    if (vldMis != 0) begin
      errors++; $display("FAIL seq_cycle: got %0d cycle mismatches, want 0", vldMis);
    end
  endtask

  task automatic test_stuck_and();
    logic [1:0] seq [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    clr = 1'b1; cyc(); clr = 1'b0;
    fault = 1;
    setIn(1'b0, 1'b0);
    repeat (40) cyc();
    foreach (seq[i]) begin
      setIn(seq[i][1], seq[i][0]);
      repeat (40) cyc();
    end
    checks++;
    if (dChk !== 16'd4 || dErrCnt !== 16'd1 || dErr !== 1'b1) begin
      errors++; $display("FAIL stuck_counts: got chk=%0d errCnt=%0d err=%b, want 4 1 1", dChk, dErrCnt, dErr);
    end
    checks++;
    if (dFail !== 5'b11010) begin
      errors++; $display("FAIL stuck_failvec: got %b, want 11010", dFail);
    end
    fault = 0;
    setIn(a, b);
  endtask

  task automatic test_restart();
    int base, c2;
    clr = 1'b1; cyc(); clr = 1'b0;
    repeat (3) cyc();
    base = nVld;
    setIn(~a, b);
    cyc();
    setIn(~a, b);
    cyc();
    c2 = cycle;
    repeat (10) cyc();
    checks++;
    if (nVld - base != 1 || lastVld != c2 + S + 1) begin
      errors++; $display("FAIL restart: got %0d pulses last at %0d, want 1 at %0d", nVld - base, lastVld, c2 + S + 1);
    end
  endtask

  task automatic test_enable();
    int base;
    logic [15:0] chk0;
    base = nVld;
    chk0 = dChk;
    en = 1'b0;
    repeat (3) begin
      setIn(a, ~b);
      repeat (5) cyc();
    end
    checks++;
    if (nVld != base || dChk !== chk0) begin
      errors++; $display("FAIL enable_hold: got %0d pulses chk=%0d, want 0 pulses chk=%0d", nVld - base, dChk, chk0);
    end
    en = 1'b1;
    setIn(~a, b);
    repeat (10) cyc();
    checks++;
    if (nVld - base != 1 || dChk !== chk0 + 16'd1) begin
      errors++; $display("FAIL enable_resume: got %0d pulses chk=%0d, want 1 pulse chk=%0d", nVld - base, dChk, chk0 + 16'd1);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    setIn(~a, b);
    cyc();
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    checks++;
    if ({dBusy, dVld, dOk, dErr, dChk, dErrCnt, dFail} !== '0) begin
      errors++; $display("FAIL rstmid_zero: got busy=%b vld=%b chk=%0d, want all 0", dBusy, dVld, dChk);
    end
    base = nVld;
    repeat (10) cyc();
    checks++;
    if (nVld != base) begin
      errors++; $display("FAIL rstmid_drop: got %0d pulses, want 0", nVld - base);
    end
    fault = 2;
    setIn(~a, b);
    repeat (6) cyc();
    checks++;
    if (dErr !== 1'b1 || dErrCnt !== 16'd1) begin
      errors++; $display("FAIL clear_pre: got err=%b errCnt=%0d, want 1 1", dErr, dErrCnt);
    end
    clr = 1'b1; cyc(); clr = 1'b0;
    checks++;
    if (dErr !== 1'b0 || dFail !== 5'd0 || dErrCnt !== 16'd0 || dChk !== 16'd0) begin
      errors++; $display("FAIL clear_post: got err=%b fail=%b errCnt=%0d chk=%0d, want all 0", dErr, dFail, dErrCnt, dChk);
    end
    fault = 0;
    setIn(a, b);
  endtask

  task automatic test_saturation();
    logic [4:0] first;
    clr = 1'b1; cyc(); clr = 1'b0;
    fault = 2;
    setIn(a, b);
    setIn(~a, b);
    first = {a, b, gAnd, gOr, gNot};
    repeat (8) cyc();
    repeat (4) begin
      setIn(~a, b);
      repeat (8) cyc();
    end
    checks++;
    if (sChk !== 2'd3 || sErrCnt !== 2'd3) begin
      errors++; $display("FAIL sat_small: got chk=%0d errCnt=%0d, want 3 3", sChk, sErrCnt);
    end
    checks++;
    if (dChk !== 16'd5 || dErrCnt !== 16'd5) begin
      errors++; $display("FAIL sat_big: got chk=%0d errCnt=%0d, want 5 5", dChk, dErrCnt);
    end
    checks++;
    if (sFail !== first || dFail !== first) begin
      errors++; $display("FAIL sat_failvec: got %b/%b, want %b", sFail, dFail, first);
    end
    fault = 0;
    setIn(a, b);
  endtask

  task automatic test_random();
    clr = 1'b1; cyc(); clr = 1'b0;
    vldMis = 0;
    repeat (80) begin
      en = ($urandom_range(0, 4) != 0);
      fault = $urandom_range(0, 2);
      setIn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 6)) cyc();
    end
    en = 1'b1;
    fault = 0;
    setIn(a, b);
    repeat (10) cyc();
    checks++;
    if (vldMis != 0) begin
      errors++; $display("FAIL rand_cycle: got %0d cycle mismatches, want 0", vldMis);
    end
    checks++;
    if (dChk !== 16'(mChk) || dErrCnt !== 16'(mErr) || dErr !== mErrFlag || dFail !== mFail) begin
      errors++; $display("FAIL rand_big: got chk=%0d err=%0d flag=%b fail=%b, want %0d %0d %b %b", dChk, dErrCnt, dErr, dFail, mChk, mErr, mErrFlag, mFail);
    end
    checks++;
    if (sChk !== 2'(sat3(mChk)) || sErrCnt !== 2'(sat3(mErr)) || sFail !== mFail) begin
      errors++; $display("FAIL rand_small: got chk=%0d err=%0d fail=%b, want %0d %0d %b", sChk, sErrCnt, sFail, sat3(mChk), sat3(mErr), mFail);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stuck_and();
    test_restart();
    test_enable();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
